// File: rtl/sphere_loader_pkg.sv
// Shared definitions for the sphere loader and the control unit it feeds:
// record geometry, memory capacity, handshake limit and FSM encodings.
package sphere_loader_pkg;

   localparam int WORDS_PER_RECORD = 8;
   localparam int MEMORY_DEPTH     = 32;
   localparam int ACK_TIMEOUT      = 255;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FILL    = 3'd1,
      ST_RDY_HI  = 3'd2,
      ST_RDY_LO  = 3'd3,
      ST_ADVANCE = 3'd4,
      ST_COMPUTE = 3'd5
   } state_t;

   // Flat word address of word 'idx' inside record 'rec' (zero-extended).
   function automatic logic [31:0] word_addr(input logic [5:0]  rec,
                                             input logic [31:0] idx,
                                             input int          wpr);
      return 32'(rec) * 32'(wpr) + idx;
   endfunction

endpackage

// File: rtl/handshake_timer.sv
// Wait counter for the rdyData/wein handshake. 'load' restarts the count at
// zero, 'en' advances it, and 'terminal' flags that LIMIT has been reached.
module handshake_timer #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic terminal
);

   localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

   logic [CW-1:0] count_reg;

   assign terminal = (count_reg == CW'(LIMIT));

   // Load has priority; the count saturates at LIMIT so it can never wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= '0;
      end else if (en && !terminal) begin
         count_reg <= count_reg + CW'(1);
      end
   end

endmodule

// File: rtl/sphere_loader.sv
// Streams sphere-pair records into the input memory, hands each completed
// record to the control unit with a rdyData/wein handshake, and releases the
// control unit into its compute phase once the session is complete or the
// memory cannot hold another record.
module sphere_loader #(
   parameter int WORDS_PER_RECORD = sphere_loader_pkg::WORDS_PER_RECORD,
   parameter int MEMORY_DEPTH     = sphere_loader_pkg::MEMORY_DEPTH,
   parameter int ACK_TIMEOUT      = sphere_loader_pkg::ACK_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  num_records,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        rdyData,
   input  logic        wein,
   output logic        rst_cu,
   output logic [5:0]  loaded_count,
   output logic        busy,
   output logic        timeout_err
);

   import sphere_loader_pkg::*;

   localparam int WIDX_W = (WORDS_PER_RECORD < 2) ? 1 : $clog2(WORDS_PER_RECORD);

   state_t            state_reg;
   logic [5:0]        num_records_reg;
   logic [5:0]        loaded_count_reg;
   logic [WIDX_W-1:0] word_idx_reg;
   logic              in_ready_reg;
   logic              rdy_data_reg;
   logic              rst_cu_reg;
   logic              busy_reg;
   logic              timeout_err_reg;

   logic              transfer;
   logic              last_word;
   logic              start_ok;
   logic [31:0]       wr_addr;
   logic [5:0]        count_inc;
   logic [31:0]       next_end;
   logic              mem_full;
   logic              rdy_phase;
   logic              timer_load;
   logic              timer_term;

   // A word moves only while FILL has in_ready raised, so writes are gated here.
   assign transfer  = in_ready_reg && in_valid;
   assign last_word = (word_idx_reg == WIDX_W'(WORDS_PER_RECORD - 1));
   assign start_ok  = start && (num_records != 6'd0);
   assign wr_addr   = word_addr(loaded_count_reg, 32'(word_idx_reg), WORDS_PER_RECORD);

   // Stop once the record after the one just finished would not fit in memory.
   assign count_inc = loaded_count_reg + 6'd1;
   assign next_end  = (32'(count_inc) + 32'd1) * 32'(WORDS_PER_RECORD);
   assign mem_full  = (next_end > 32'(MEMORY_DEPTH));

   // Timer runs only during the handshake and restarts for the falling edge.
   assign rdy_phase  = (state_reg == ST_RDY_HI) || (state_reg == ST_RDY_LO);
   assign timer_load = !rdy_phase || ((state_reg == ST_RDY_HI) && wein);

   handshake_timer #(
      .LIMIT    (ACK_TIMEOUT)
   ) u_handshake_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .en       (rdy_phase),
      .terminal (timer_term)
   );

   assign in_ready     = in_ready_reg;
   assign mem_we       = transfer;
   assign mem_addr     = transfer ? wr_addr : 32'd0;
   assign mem_wdata    = transfer ? in_data : 32'd0;
   assign rdyData      = rdy_data_reg;
   assign rst_cu       = rst_cu_reg;
   assign loaded_count = loaded_count_reg;
   assign busy         = busy_reg;
   assign timeout_err  = timeout_err_reg;

   // Session FSM with registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         num_records_reg  <= '0;
         loaded_count_reg <= '0;
         word_idx_reg     <= '0;
         in_ready_reg     <= 1'b0;
         rdy_data_reg     <= 1'b0;
         rst_cu_reg       <= 1'b0;
         busy_reg         <= 1'b0;
         timeout_err_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start_ok) begin
                  state_reg        <= ST_FILL;
                  num_records_reg  <= num_records;
                  loaded_count_reg <= '0;
                  word_idx_reg     <= '0;
                  in_ready_reg     <= 1'b1;
                  busy_reg         <= 1'b1;
               end
            end
            ST_FILL: begin
               if (transfer) begin
                  if (last_word) begin
                     state_reg    <= ST_RDY_HI;
                     word_idx_reg <= '0;
                     in_ready_reg <= 1'b0;
                     rdy_data_reg <= 1'b1;
                  end else begin
                     word_idx_reg <= word_idx_reg + WIDX_W'(1);
                  end
               end
            end
            ST_RDY_HI: begin
               if (wein) begin
                  state_reg    <= ST_RDY_LO;
                  rdy_data_reg <= 1'b0;
               end else if (timer_term) begin
                  state_reg       <= ST_IDLE;
                  rdy_data_reg    <= 1'b0;
                  busy_reg        <= 1'b0;
                  timeout_err_reg <= 1'b1;
               end
            end
            ST_RDY_LO: begin
               if (!wein) begin
                  state_reg <= ST_ADVANCE;
               end else if (timer_term) begin
                  state_reg       <= ST_IDLE;
                  busy_reg        <= 1'b0;
                  timeout_err_reg <= 1'b1;
               end
            end
            ST_ADVANCE: begin
               loaded_count_reg <= count_inc;
               if ((count_inc == num_records_reg) || mem_full) begin
                  state_reg  <= ST_COMPUTE;
                  rst_cu_reg <= 1'b1;
               end else begin
                  state_reg    <= ST_FILL;
                  word_idx_reg <= '0;
                  in_ready_reg <= 1'b1;
               end
            end
            ST_COMPUTE: begin
               if (start_ok) begin
                  state_reg        <= ST_FILL;
                  num_records_reg  <= num_records;
                  loaded_count_reg <= '0;
                  word_idx_reg     <= '0;
                  in_ready_reg     <= 1'b1;
                  rst_cu_reg       <= 1'b0;
               end
            end
            default: begin
               state_reg    <= ST_IDLE;
               in_ready_reg <= 1'b0;
               rdy_data_reg <= 1'b0;
               rst_cu_reg   <= 1'b0;
               busy_reg     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sphere_loader.sv
// Directed bench for sphere_loader: full sessions, gapped input, memory-full
// cutoff, stray start, handshake timeout and mid-session reset.
module tb_sphere_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [5:0]  num_records;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        rdyData;
   logic        wein;
   logic        rst_cu;
   logic [5:0]  loaded_count;
   logic        busy;
   logic        timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   bit          ack_enable = 1'b1;
   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];
   bit          rdy_seen = 1'b0;
   int          writes_at_rdy = -1;

   sphere_loader dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .num_records  (num_records),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .rdyData      (rdyData),
      .wein         (wein),
      .rst_cu       (rst_cu),
      .loaded_count (loaded_count),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      rdy_seen      = 1'b0;
      writes_at_rdy = -1;
   endtask

   task automatic pulse_start(input logic [5:0] n);
      num_records = n;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   // Offers n words (data = base + k); gappy raises in_valid every other cycle.
   task automatic feed_words(input int n, input logic [31:0] base, input bit gappy);
      int sent = 0;
      int cyc  = 0;
      bit phase = 1'b1;
      bit xfer;
      while (sent < n && cyc < 2000) begin
         in_data  = base + 32'(sent);
         in_valid = gappy ? phase : 1'b1;
         phase    = ~phase;
         @(negedge clk);
         xfer = in_valid && in_ready;
         tick();
         cyc++;
         if (xfer) sent++;
      end
      in_valid = 1'b0;
      check_value("feed_done", 32'(sent), 32'(n));
   endtask

   task automatic wait_compute(input string tag);
      int c = 0;
      while (rst_cu !== 1'b1 && c < 500) begin
         tick();
         c++;
      end
      check_value(tag, 32'(rst_cu), 32'd1);
   endtask

   // Expected: n writes to addresses 0..n-1 carrying data base+k.
   task automatic check_log(input string tag, input int n, input logic [31:0] base);
      check_value({tag, "_count"}, 32'(log_addr.size()), 32'(n));
      for (int k = 0; k < n && k < log_addr.size(); k++) begin
         check_value($sformatf("%s_addr[%0d]", tag, k), log_addr[k], 32'(k));
         check_value($sformatf("%s_data[%0d]", tag, k), log_data[k], base + 32'(k));
      end
   endtask

   // Write and handshake observer, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         log_addr.push_back(mem_addr);
         log_data.push_back(mem_wdata);
      end
      if (rdyData === 1'b1 && !rdy_seen) begin
         rdy_seen      = 1'b1;
         writes_at_rdy = log_addr.size();
      end
   end

   // Control-unit model: raise wein a few cycles after rdyData, drop it 2 later.
   initial begin
      wein = 1'b0;
      forever begin
         tick();
         if (ack_enable && rdyData === 1'b1) begin
            repeat (2) tick();
            wein = 1'b1;
            repeat (2) tick();
            wein = 1'b0;
         end
      end
   end

   initial begin
      int k;
      rst = 1'b1; start = 1'b0; num_records = '0; in_data = '0; in_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      check_value("rst_in_ready", 32'(in_ready), 32'd0);
      check_value("rst_busy", 32'(busy), 32'd0);
      check_value("rst_rdy", 32'(rdyData), 32'd0);
      check_value("rst_rst_cu", 32'(rst_cu), 32'd0);
      check_value("rst_count", 32'(loaded_count), 32'd0);
      check_value("rst_timeout", 32'(timeout_err), 32'd0);
      check_value("rst_mem_we", 32'(mem_we), 32'd0);

      // start with zero records is ignored
      pulse_start(6'd0);
      tick();
      check_value("zero_start_busy", 32'(busy), 32'd0);
      check_value("zero_start_ready", 32'(in_ready), 32'd0);
      $display("txn zero_start: busy=%0b", busy);

      // Two records back-to-back
      clear_log();
      pulse_start(6'd2);
      check_value("s1_busy", 32'(busy), 32'd1);
      feed_words(16, 32'hA000_0000, 1'b0);
      wait_compute("s1_compute");
      check_log("s1", 16, 32'hA000_0000);
      check_value("s1_count", 32'(loaded_count), 32'd2);
      check_value("s1_busy_c", 32'(busy), 32'd1);
      // in_valid outside FILL must not write
      in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      check_value("s1_no_stray_we", 32'(log_addr.size()), 32'd16);
      $display("txn session2: writes=%0d count=%0d", log_addr.size(), loaded_count);

      // Gapped stream, one record, restarted from COMPUTE
      clear_log();
      pulse_start(6'd1);
      check_value("s2_rst_cu_low", 32'(rst_cu), 32'd0);
      feed_words(8, 32'hB000_0000, 1'b1);
      wait_compute("s2_compute");
      check_log("s2", 8, 32'hB000_0000);
      check_value("s2_rdy_after_8", 32'(writes_at_rdy), 32'd8);
      check_value("s2_count", 32'(loaded_count), 32'd1);
      $display("txn gapped: writes=%0d rdy_at=%0d", log_addr.size(), writes_at_rdy);

      // Memory-full cutoff: 10 requested, 4 fit
      clear_log();
      pulse_start(6'd10);
      feed_words(32, 32'hC000_0000, 1'b0);
      wait_compute("s3_compute");
      check_log("s3", 32, 32'hC000_0000);
      check_value("s3_count", 32'(loaded_count), 32'd4);
      check_value("s3_in_ready", 32'(in_ready), 32'd0);
      $display("txn memfull: writes=%0d count=%0d", log_addr.size(), loaded_count);

      // Stray start during RDY_HI
      clear_log();
      pulse_start(6'd2);
      fork
         feed_words(16, 32'hD000_0000, 1'b0);
         begin
            int c = 0;
            while (rdyData !== 1'b1 && c < 200) begin
               tick();
               c++;
            end
            check_value("s4_rdy_seen", 32'(rdyData), 32'd1);
            num_records = 6'd5;
            start       = 1'b1;
            tick();
            start       = 1'b0;
         end
      join
      wait_compute("s4_compute");
      check_log("s4", 16, 32'hD000_0000);
      check_value("s4_count", 32'(loaded_count), 32'd2);
      $display("txn stray_start: writes=%0d count=%0d", log_addr.size(), loaded_count);

      // Handshake timeout: no wein
      ack_enable = 1'b0;
      pulse_start(6'd1);
      feed_words(8, 32'hE000_0000, 1'b0);
      check_value("s5_rdy_high", 32'(rdyData), 32'd1);
      k = 0;
      while (timeout_err !== 1'b1 && k < 400) begin
         tick();
         k++;
      end
      check_value("s5_timeout_window", 32'(k >= 255 && k <= 257), 32'd1);
      check_value("s5_timeout", 32'(timeout_err), 32'd1);
      check_value("s5_rdy_low", 32'(rdyData), 32'd0);
      check_value("s5_busy", 32'(busy), 32'd0);
      check_value("s5_rst_cu", 32'(rst_cu), 32'd0);
      tick();
      check_value("s5_sticky", 32'(timeout_err), 32'd1);
      ack_enable = 1'b1;
      $display("txn timeout: cycles=%0d err=%0b", k, timeout_err);

      // Reset after the 5th word of the second record
      clear_log();
      pulse_start(6'd2);
      feed_words(13, 32'hF000_0000, 1'b0);
      check_value("s6_count_mid", 32'(loaded_count), 32'd1);
      in_valid = 1'b1;
      rst      = 1'b1;
      tick();
      check_value("s6_in_ready", 32'(in_ready), 32'd0);
      check_value("s6_mem_we", 32'(mem_we), 32'd0);
      check_value("s6_mem_addr", mem_addr, 32'd0);
      check_value("s6_mem_wdata", mem_wdata, 32'd0);
      check_value("s6_rdy", 32'(rdyData), 32'd0);
      check_value("s6_rst_cu", 32'(rst_cu), 32'd0);
      check_value("s6_count", 32'(loaded_count), 32'd0);
      check_value("s6_busy", 32'(busy), 32'd0);
      check_value("s6_timeout", 32'(timeout_err), 32'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();
      clear_log();
      pulse_start(6'd1);
      feed_words(8, 32'h1234_0000, 1'b0);
      wait_compute("s6_compute");
      check_log("s6", 8, 32'h1234_0000);
      check_value("s6_final_count", 32'(loaded_count), 32'd1);
      $display("txn reset_restart: writes=%0d first_addr=%0d", log_addr.size(),
               (log_addr.size() > 0) ? log_addr[0] : 32'hFFFF_FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
